// File: rtl/bit_permute_pkg.sv
// Shared definitions for the bit permutation pipeline: mode encoding and
// a helper that tells whether a mode code selects a real permutation.
package bit_permute_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        PM_PASS   = 3'd0,
        PM_REV    = 3'd1,
        PM_SHR    = 3'd2,
        PM_ROTL   = 3'd3,
        PM_SWAPH  = 3'd4,
        PM_PAIRSW = 3'd5
    } perm_mode_e;

    // Codes above PM_PAIRSW are reserved and flagged as errors downstream.
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] mode);
        return mode <= PM_PAIRSW;
    endfunction

endpackage

// File: rtl/bit_permute_core.sv
// Purely combinational permutation network. One beat in, one permuted
// word out, plus a flag for reserved mode codes (which produce zero).
// WIDTH must be a power of two and at least 4, so every amt value is
// already a legal shift/rotate distance.
module bit_permute_core
    import bit_permute_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  data,
    input  logic [MODE_W-1:0] mode,
    input  logic [AMT_W-1:0]  amt,
    output logic [WIDTH-1:0]  result,
    output logic              illegal
);

    logic [WIDTH-1:0]   rev_bits;
    logic [WIDTH-1:0]   pair_bits;
    logic [2*WIDTH-1:0] rot_wide;

    // Rotating a doubled copy left leaves the rotated word in the upper half.
    assign rot_wide = {data, data} << amt;

    // Fixed wiring patterns: full bit reversal and adjacent-pair exchange.
    always_comb begin
        rev_bits  = '0;
        pair_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_bits[i]  = data[WIDTH-1-i];
            pair_bits[i] = data[i ^ 1];
        end
    end

    // Select the permutation for this beat; reserved codes yield zero.
    always_comb begin
        result  = '0;
        illegal = !mode_is_legal(mode);
        case (mode)
            PM_PASS:   result = data;
            PM_REV:    result = rev_bits;
            PM_SHR:    result = data >> amt;
            PM_ROTL:   result = rot_wide[2*WIDTH-1:WIDTH];
            PM_SWAPH:  result = {data[WIDTH/2-1:0], data[WIDTH-1:WIDTH/2]};
            PM_PAIRSW: result = pair_bits;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/bit_permute_pipe.sv
// Two-stage valid/ready pipeline around bit_permute_core. S1 registers the
// raw beat, S2 registers the permuted word and its error bit and drives the
// output side. Stalls propagate combinationally back to in_ready (no skid
// buffer), so a full pipe still moves one beat per cycle when out_ready=1.
module bit_permute_pipe
    import bit_permute_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 16,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  beat_count
);

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_data;
    logic [MODE_W-1:0] s1_mode;
    logic [AMT_W-1:0]  s1_amt;

    logic              s2_valid;
    logic [WIDTH-1:0]  s2_data;
    logic              s2_err;

    logic [WIDTH-1:0]  perm_result;
    logic              perm_illegal;

    logic              adv1;
    logic              adv2;
    logic              in_fire;

    // A stage may load when it is empty or its contents move on this cycle.
    assign adv2    = !s2_valid || out_ready;
    assign adv1    = !s1_valid || adv2;
    assign in_ready = adv1;
    assign in_fire = in_valid && adv1;

    assign out_valid  = s2_valid;
    assign out_data   = s2_data;
    assign out_err    = s2_err;

    bit_permute_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .data    (s1_data),
        .mode    (s1_mode),
        .amt     (s1_amt),
        .result  (perm_result),
        .illegal (perm_illegal)
    );

    // S1: capture the incoming beat whenever the stage is free to advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
            s1_amt   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
                s1_amt  <= in_amt;
            end
        end
    end

    // S2: register the permuted word; held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= perm_result;
                s2_err  <= perm_illegal;
            end
        end
    end

    // Sticky error flag: set as soon as a reserved-mode beat lands in S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (adv2 && s1_valid && perm_illegal) begin
            err_sticky <= 1'b1;
        end
    end

    // Accepted-beat counter that stops at its maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
        end else if (in_fire && (beat_count != {CNT_W{1'b1}})) begin
            beat_count <= beat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Testbench for bit_permute_pipe: directed scenarios plus a randomized run
// compared against an arithmetic reference model and an expectation queue.
module tb_bit_permute_pipe;
    import bit_permute_pkg::*;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [2:0]    in_mode;
    logic [AW-1:0] in_amt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    logic          err_sticky;
    logic [15:0]   beat_count;

    logic          small_valid;
    logic          small_in_ready;
    logic          small_out_valid;
    logic [W-1:0]  small_out_data;
    logic          small_out_err;
    logic          small_err_sticky;
    logic [1:0]    small_beat_count;

    int            checks = 0;
    int            errors = 0;
    logic [W:0]    exp_q[$];
    int            exp_count = 0;
    logic          exp_sticky = 1'b0;

    always #5 clk = ~clk;

    bit_permute_pipe #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .err_sticky(err_sticky), .beat_count(beat_count)
    );

    bit_permute_pipe #(.WIDTH(W), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(small_valid), .in_ready(small_in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_amt(in_amt),
        .out_valid(small_out_valid), .out_ready(1'b1),
        .out_data(small_out_data), .out_err(small_out_err),
        .err_sticky(small_err_sticky), .beat_count(small_beat_count)
    );

    // Reference permutation from the mode rules using integer arithmetic.
    function automatic logic [W:0] model(input int d, input int mode, input int amt);
        int r;
        r = 0;
        case (mode)
            0: r = d;
            1: for (int i = 0; i < W; i++) if ((d / (2 ** i)) % 2 == 1) r += 2 ** (W - 1 - i);
            2: r = d / (2 ** amt);
            3: r = (d * (2 ** amt)) % (2 ** W) + d / (2 ** (W - amt));
            4: r = (d % (2 ** (W / 2))) * (2 ** (W / 2)) + d / (2 ** (W / 2));
            5: for (int i = 0; i < W; i++) if ((d / (2 ** i)) % 2 == 1) r += 2 ** (i ^ 1);
            default: return {1'b1, {W{1'b0}}};
        endcase
        return {1'b0, r[W-1:0]};
    endfunction

    // One cycle: sample handshakes mid-cycle, record accepted beats, step clock.
    task automatic tick(output logic acc, output logic took, output logic ov,
                        output logic [W-1:0] od, output logic oe);
        logic [W:0] m;
        @(negedge clk);
        acc  = in_valid && in_ready;
        ov   = out_valid;
        took = out_valid && out_ready;
        od   = out_data;
        oe   = out_err;
        if (acc) begin
            m = model(int'(in_data), int'(in_mode), int'(in_amt));
            exp_q.push_back(m);
            if (exp_count < 65535) exp_count++;
            if (m[W]) exp_sticky = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_err !== 1'b0 ||
            err_sticky !== 1'b0 || beat_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: valid=%b ready=%b data=%h err=%b sticky=%b count=%0d, expected 0 1 00 0 0 0",
                     out_valid, in_ready, out_data, out_err, err_sticky, beat_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dd[3] = '{'hA5, 'hB4, 'h01};
        int md[3] = '{0, 1, 1};
        int ed[3] = '{'hA5, 'h2D, 'h80};
        logic acc, took, ov, oe;
        logic [W-1:0] od;
        logic [W:0] e;
        int got = 0;
        int first = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (c < 3) begin
                in_valid = 1'b1; in_data = W'(dd[c]); in_mode = 3'(md[c]); in_amt = AW'($urandom);
            end else in_valid = 1'b0;
            tick(acc, took, ov, od, oe);
            if (took) begin
                if (first < 0) first = c;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (od !== W'(ed[got]) || od !== e[W-1:0] || oe !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_data beat %0d: got %h err %b, expected %h err 0", got, od, oe, ed[got]);
                end
                checks++;
                if (c != first + got) begin
                    errors++;
                    $display("[TB] FAIL b2b_gap beat %0d: got cycle %0d, expected %0d", got, c, first + got);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (first != 2) begin
            errors++;
            $display("[TB] FAIL b2b_latency: first output on cycle %0d, expected 2", first);
        end
        checks++;
        if (beat_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d, expected 3", beat_count);
        end
    endtask

    task automatic test_modes();
        int md[7] = '{2, 3, 3, 2, 4, 5, 4};
        int dd[7] = '{'hFF, 'h81, 'h5A, 'h80, 'h3C, 'h12, 'hF0};
        int ad[7] = '{2, 3, 0, 7, 0, 0, 0};
        int ed[7] = '{'h3F, 'h0C, 'h5A, 'h01, 'hC3, 'h21, 'h0F};
        logic acc, took, ov, oe;
        logic [W-1:0] od;
        logic [W:0] e;
        int got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 7; c++) begin
            if (c < 7) begin
                in_valid = 1'b1; in_data = W'(dd[c]); in_mode = 3'(md[c]); in_amt = AW'(ad[c]);
            end else in_valid = 1'b0;
            tick(acc, took, ov, od, oe);
            if (took) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (od !== W'(ed[got]) || od !== e[W-1:0] || oe !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mode_vec %0d (mode %0d): got %h err %b, expected %h err 0",
                             got, md[got], od, oe, ed[got]);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 7) begin
            errors++;
            $display("[TB] FAIL mode_drain: got %0d outputs, expected 7", got);
        end
    endtask

    task automatic test_backpressure();
        logic acc, took, ov, oe;
        logic [W-1:0] od;
        logic [W:0] e;
        int idx = 0;
        int got = 0;
        out_ready = 1'b0;
        in_mode = 3'(PM_PASS);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = W'(idx + 1);
            tick(acc, took, ov, od, oe);
            if (acc) idx++;
        end
        checks++;
        if (idx != 2) begin
            errors++;
            $display("[TB] FAIL bp_accepted: got %0d, expected 2", idx);
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h01) begin
            errors++;
            $display("[TB] FAIL bp_stall: ready=%b valid=%b data=%h, expected 0 1 01", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (idx < 4) begin
                in_valid = 1'b1; in_data = W'(idx + 1);
            end else in_valid = 1'b0;
            tick(acc, took, ov, od, oe);
            if (acc) idx++;
            if (took) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (od !== W'(got + 1) || od !== e[W-1:0] || c != got) begin
                    errors++;
                    $display("[TB] FAIL bp_release beat %0d: got %h on cycle %0d, expected %h on cycle %0d",
                             got, od, c, got + 1, got);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %0d outputs, expected 4", got);
        end
    endtask

    task automatic test_illegal();
        int md[3] = '{0, 6, 0};
        int dd[3] = '{'h11, 'hFF, 'h22};
        int ed[3] = '{'h11, 'h00, 'h22};
        logic acc, took, ov, oe;
        logic [W-1:0] od;
        logic [W:0] e;
        int got = 0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sticky_pre: got %b, expected 0", err_sticky);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hFF; in_mode = 3'd7;
        tick(acc, took, ov, od, oe);
        in_valid = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sticky_s1: got %b, expected 0 while beat in S1", err_sticky);
        end
        tick(acc, took, ov, od, oe);
        checks++;
        if (err_sticky !== 1'b1 || out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL sticky_s2: sticky=%b valid=%b err=%b data=%h, expected 1 1 1 00",
                     err_sticky, out_valid, out_err, out_data);
        end
        out_ready = 1'b1;
        tick(acc, took, ov, od, oe);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (!took || od !== e[W-1:0] || oe !== e[W] || oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal7_out: took=%b data=%h err=%b, expected 1 00 1", took, od, oe);
        end
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (c < 3) begin
                in_valid = 1'b1; in_data = W'(dd[c]); in_mode = 3'(md[c]); in_amt = AW'($urandom);
            end else in_valid = 1'b0;
            tick(acc, took, ov, od, oe);
            if (took) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (od !== W'(ed[got]) || oe !== (got == 1) || od !== e[W-1:0] || oe !== e[W]) begin
                    errors++;
                    $display("[TB] FAIL illegal_seq beat %0d: got %h err %b, expected %h err %b",
                             got, od, oe, ed[got], got == 1);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        repeat (3) tick(acc, took, ov, od, oe);
        checks++;
        if (got != 3 || err_sticky !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_hold: outputs=%0d sticky=%b, expected 3 1", got, err_sticky);
        end
    endtask

    task automatic test_reset_midflight();
        logic acc, took, ov, oe;
        logic [W-1:0] od;
        int stale = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 3'(PM_PASS); in_data = 8'h33;
        tick(acc, took, ov, od, oe);
        in_data = 8'h44;
        tick(acc, took, ov, od, oe);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_setup: out_valid=%b, expected 1", out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || beat_count !== 16'd0 || err_sticky !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid: valid=%b count=%0d sticky=%b ready=%b, expected 0 0 0 1",
                     out_valid, beat_count, err_sticky, in_ready);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_count = 0;
        exp_sticky = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(acc, took, ov, od, oe);
            if (ov) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("[TB] FAIL rst_stale: got %0d stale outputs, expected 0", stale);
        end
    endtask

    task automatic test_saturate();
        int n = 0;
        logic acc;
        for (int c = 0; c < 5; c++) begin
            small_valid = 1'b1;
            @(negedge clk);
            acc = small_valid && small_in_ready;
            @(posedge clk);
            #1;
            if (acc) n++;
            checks++;
            if (small_beat_count !== 2'((n > 3) ? 3 : n)) begin
                errors++;
                $display("[TB] FAIL sat_count after %0d beats: got %0d, expected %0d",
                         n, small_beat_count, (n > 3) ? 3 : n);
            end
        end
        small_valid = 1'b0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("[TB] FAIL sat_accepts: got %0d, expected 5", n);
        end
    endtask

    task automatic test_random();
        logic acc, took, ov, oe;
        logic [W-1:0] od;
        logic [W:0] e;
        logic prev_stall;
        logic [W-1:0] prev_d;
        logic prev_e;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_e = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c < 500) begin
                if (!in_valid && $urandom_range(3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = W'($urandom);
                    in_mode  = 3'($urandom_range(7));
                    in_amt   = AW'($urandom);
                end
                out_ready = ($urandom_range(9) < 7);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            tick(acc, took, ov, od, oe);
            if (acc) in_valid = 1'b0;
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || od !== prev_d || oe !== prev_e) begin
                    errors++;
                    $display("[TB] FAIL rand_hold cycle %0d: valid=%b data=%h err=%b, expected 1 %h %b",
                             c, ov, od, oe, prev_d, prev_e);
                end
            end
            prev_stall = ov && !took;
            prev_d = od;
            prev_e = oe;
            if (took) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra cycle %0d: got %h, expected no beat", c, od);
                end else begin
                    e = exp_q.pop_front();
                    if (od !== e[W-1:0] || oe !== e[W]) begin
                        errors++;
                        $display("[TB] FAIL rand_data cycle %0d: got %h err %b, expected %h err %b",
                                 c, od, oe, e[W-1:0], e[W]);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_drain: %0d beats missing, expected 0", exp_q.size());
        end
        checks++;
        if (beat_count !== 16'(exp_count)) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d, expected %0d", beat_count, exp_count);
        end
        checks++;
        if (err_sticky !== exp_sticky) begin
            errors++;
            $display("[TB] FAIL rand_sticky: got %b, expected %b", err_sticky, exp_sticky);
        end
    endtask

    // Hard stop in case the design wedges somewhere a bounded loop cannot see.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_mode = '0;
        in_amt = '0;
        out_ready = 1'b1;
        small_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_modes();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
